divide_tokens_multi: RTL and testbench

- Multi-channel token rate divider; generalises the every-other-token halver to a runtime-selectable divide ratio across CHANNELS independent single-bit token streams.
- Each channel passes exactly one of every DIV input tokens (token = input high for one cycle); all others are dropped.
- Keep-first or keep-last selection per mode; per-channel saturating pass counters for monitoring.
- Sits between token-generating sequential blocks and downstream consumers that need a decimated pulse rate.

---
 rtl/divide_tokens_pkg.sv | 13 +
 rtl/divide_tokens_lane.sv | 59 +++++
 rtl/divide_tokens_multi.sv | 72 +++++++
 tb/tb_divide_tokens_multi.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/divide_tokens_pkg.sv
// Shared types and defaults for the multi-lane token rate divider.
package divide_tokens_pkg;

    typedef enum logic {KEEP_FIRST = 1'b0, KEEP_LAST = 1'b1} keep_mode_t;

    localparam int unsigned DEF_DIV  = 2;
    localparam keep_mode_t  DEF_MODE = KEEP_LAST;

    function automatic int unsigned div_w(input int unsigned max_div);
        return $clog2(max_div + 1);
    endfunction

endpackage

// File: rtl/divide_tokens_lane.sv
// One token lane: phase counter, pass decision, registered pulse and saturating pass counter.
module divide_tokens_lane
    import divide_tokens_pkg::*;
#(
    parameter int unsigned DIV_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    input  keep_mode_t       keep_mode,
    input  logic             a,
    output logic             b,
    output logic [CNT_W-1:0] pass_cnt,
    output logic             pass_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DIV_W-1:0] phase;
    logic [DIV_W-1:0] phase_base_c;
    logic [DIV_W-1:0] phase_last_c;
    logic [DIV_W-1:0] phase_nxt_c;
    logic             pass_c;

    // A clear coincident with a token makes that token phase 0.
    always_comb begin
        phase_base_c = clr ? '0 : phase;
        phase_last_c = div - DIV_W'(1);
        phase_nxt_c  = phase_base_c;
        pass_c       = 1'b0;
        if (en && a) begin
            pass_c      = (keep_mode == KEEP_LAST) ? (phase_base_c == phase_last_c)
                                                   : (phase_base_c == '0);
            phase_nxt_c = (phase_base_c == phase_last_c) ? '0 : phase_base_c + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            b        <= 1'b0;
            pass_cnt <= '0;
            pass_sat <= 1'b0;
        end else begin
            phase <= phase_nxt_c;
            b     <= pass_c;
            if (pass_c && pass_cnt != CNT_MAX) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
            if (pass_c && pass_cnt == CNT_MAX - CNT_W'(1)) begin
                pass_sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/divide_tokens_multi.sv
// Multi-channel token rate divider: shared divisor/mode latch feeding CHANNELS independent lanes.
module divide_tokens_multi
    import divide_tokens_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MAX_DIV  = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         cfg_load,
    input  logic [$clog2(MAX_DIV+1)-1:0] div_in,
    input  logic                         keep_last_in,
    input  logic [CHANNELS-1:0]          clr,
    input  logic [CHANNELS-1:0]          a,
    output logic [CHANNELS-1:0]          b,
    output logic [CHANNELS*CNT_W-1:0]    pass_cnt,
    output logic [CHANNELS-1:0]          pass_sat
);

    localparam int unsigned DIV_W = div_w(MAX_DIV);

    logic [DIV_W-1:0] div_active;
    logic [DIV_W-1:0] div_clamp_c;
    logic [DIV_W-1:0] div_eff_c;
    keep_mode_t       keep_active;
    keep_mode_t       keep_in_c;
    keep_mode_t       keep_eff_c;

    // A loading cycle already runs under the new configuration.
    always_comb begin
        div_clamp_c = div_in;
        if (div_in <= DIV_W'(1)) begin
            div_clamp_c = DIV_W'(1);
        end else if (div_in > DIV_W'(MAX_DIV)) begin
            div_clamp_c = DIV_W'(MAX_DIV);
        end
        keep_in_c  = keep_last_in ? KEEP_LAST : KEEP_FIRST;
        div_eff_c  = cfg_load ? div_clamp_c : div_active;
        keep_eff_c = cfg_load ? keep_in_c : keep_active;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_active  <= DIV_W'(DEF_DIV);
            keep_active <= DEF_MODE;
        end else if (cfg_load) begin
            div_active  <= div_clamp_c;
            keep_active <= keep_in_c;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        divide_tokens_lane #(
            .DIV_W(DIV_W),
            .CNT_W(CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .clr      (cfg_load | clr[i]),
            .div      (div_eff_c),
            .keep_mode(keep_eff_c),
            .a        (a[i]),
            .b        (b[i]),
            .pass_cnt (pass_cnt[i*CNT_W +: CNT_W]),
            .pass_sat (pass_sat[i])
        );
    end

endmodule

// File: tb/tb_divide_tokens_multi.sv
// Self-checking bench: directed scenarios plus random traffic against a token-count reference model.
module tb_divide_tokens_multi;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned MAX_DIV  = 16;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned DIV_W    = $clog2(MAX_DIV + 1);
    localparam int          CNT_TOP  = (1 << CNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic                      cfg_load;
    logic [DIV_W-1:0]          div_in;
    logic                      keep_last_in;
    logic [CHANNELS-1:0]       clr;
    logic [CHANNELS-1:0]       a;
    logic [CHANNELS-1:0]       b;
    logic [CHANNELS*CNT_W-1:0] pass_cnt;
    logic [CHANNELS-1:0]       pass_sat;

    always #5 clk = ~clk;

    divide_tokens_multi #(
        .CHANNELS(CHANNELS),
        .MAX_DIV (MAX_DIV),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_load    (cfg_load),
        .div_in      (div_in),
        .keep_last_in(keep_last_in),
        .clr         (clr),
        .a           (a),
        .b           (b),
        .pass_cnt    (pass_cnt),
        .pass_sat    (pass_sat)
    );

    int checks = 0;
    int errors = 0;

    // Reference: tokens seen since the last clear; a token passes when its index lands on the kept slot.
    int                  m_div;
    bit                  m_keep_last;
    int                  m_tok   [CHANNELS];
    int                  m_passes[CHANNELS];
    logic [CHANNELS-1:0] m_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lane_cnt(input int i);
        logic [CHANNELS*CNT_W-1:0] v;
        v = pass_cnt;
        return int'(v[i*CNT_W +: CNT_W]);
    endfunction

    task automatic model_step(input bit r, input bit e, input bit ld, input int d, input bit k,
                              input logic [CHANNELS-1:0] c, input logic [CHANNELS-1:0] av);
        int slot;
        m_b = '0;
        if (r) begin
            m_div       = 2;
            m_keep_last = 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                m_tok[i]    = 0;
                m_passes[i] = 0;
            end
            return;
        end
        if (ld) begin
            m_div       = (d <= 1) ? 1 : (d > MAX_DIV) ? MAX_DIV : d;
            m_keep_last = k;
            for (int i = 0; i < CHANNELS; i++) m_tok[i] = 0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (c[i]) m_tok[i] = 0;
            if (e && av[i]) begin
                slot = m_tok[i] % m_div;
                if (slot == (m_keep_last ? m_div - 1 : 0)) begin
                    m_b[i] = 1'b1;
                    m_passes[i]++;
                end
                m_tok[i]++;
            end
        end
    endtask

    task automatic tick(input bit r, input bit e, input bit ld, input int d, input bit k,
                        input logic [CHANNELS-1:0] c, input logic [CHANNELS-1:0] av);
        logic [CHANNELS-1:0] exp_sat;
        rst          = r;
        en           = e;
        cfg_load     = ld;
        div_in       = DIV_W'(d);
        keep_last_in = k;
        clr          = c;
        a            = av;
        @(posedge clk);
        model_step(r, e, ld, d, k, c, av);
        #1;
        check("b", 64'(b), 64'(m_b));
        exp_sat = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            check($sformatf("pass_cnt[%0d]", i), 64'(lane_cnt(i)),
                  64'((m_passes[i] >= CNT_TOP) ? CNT_TOP : m_passes[i]));
            exp_sat[i] = (m_passes[i] >= CNT_TOP);
        end
        check("pass_sat", 64'(pass_sat), 64'(exp_sat));
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick(0, 1, 0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic load(input int d, input bit k);
        tick(0, 1, 1, d, k, '0, '0);
    endtask

    task automatic tokens(input int lane, input int n, input bit e);
        logic [CHANNELS-1:0] m;
        m = CHANNELS'(1) << lane;
        for (int j = 0; j < n; j++) tick(0, e, 0, 0, 0, '0, m);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0; div_in = '0;
        keep_last_in = 1'b0; clr = '0; a = '0;
        m_div = 2; m_keep_last = 1'b1; m_b = '0;
        for (int i = 0; i < CHANNELS; i++) begin m_tok[i] = 0; m_passes[i] = 0; end

        // Reset defaults: halver keeping 2nd, 4th, 6th token.
        do_reset();
        do_reset();
        tokens(0, 6, 1);
        idle(1);
        check("default_cnt0", 64'(lane_cnt(0)), 64'd3);

        // Divide-by-3 keep-first on lane 1.
        do_reset();
        load(3, 0);
        tokens(1, 7, 1);
        idle(1);
        check("div3_cnt1", 64'(lane_cnt(1)), 64'd3);
        check("div3_cnt0", 64'(lane_cnt(0)), 64'd0);

        // Clamp low to pass-through, then clamp high to MAX_DIV keep-last.
        do_reset();
        load(0, 0);
        tokens(0, 5, 1);
        idle(1);
        check("div0_cnt0", 64'(lane_cnt(0)), 64'd5);
        load(31, 1);
        tokens(0, 32, 1);
        idle(1);
        check("div31_cnt0", 64'(lane_cnt(0)), 64'd7);

        // Clear coincident with token on lane 2 at phase 3 under div 4 keep-last.
        do_reset();
        load(4, 1);
        tokens(2, 3, 1);
        tick(0, 1, 0, 0, 0, 4'b0100, 4'b0100);
        tokens(2, 2, 1);
        check("clr_no_pass", 64'(lane_cnt(2)), 64'd0);
        tokens(2, 1, 1);
        idle(1);
        check("clr_cnt2", 64'(lane_cnt(2)), 64'd1);

        // Enable gating holds phase.
        do_reset();
        tokens(0, 1, 1);
        tokens(0, 5, 0);
        tokens(0, 1, 1);
        idle(1);
        check("en_cnt0", 64'(lane_cnt(0)), 64'd1);

        // Coincident token with cfg_load is phase 0 under the new config.
        tick(0, 1, 1, 3, 0, '0, 4'b1111);
        tokens(3, 3, 1);

        // Reset overrides cfg_load.
        tick(1, 1, 1, 5, 0, 4'b1111, 4'b1111);
        tokens(0, 2, 1);
        idle(1);
        check("rst_ovr_cnt0", 64'(lane_cnt(0)), 64'd1);

        // Saturation on lane 3 with pass-through.
        do_reset();
        load(1, 0);
        tokens(3, 20, 1);
        idle(1);
        check("sat_cnt3", 64'(lane_cnt(3)), 64'(CNT_TOP));
        check("sat_flags", 64'(pass_sat), 64'b1000);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tick(($urandom_range(0, 249) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 39) == 0),
                 int'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)),
                 CHANNELS'({$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0}),
                 CHANNELS'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
